// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared widths, fetch constants and queue entry type
// Provides INSN_W / ADDR_W, the default reset PC, the PC increment, and the
// {pc, insn} record stored in the fetch instruction queue.
package mips_pkg;
    localparam int INSN_W = 32;
    localparam int ADDR_W = 32;

    localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [ADDR_W-1:0] PC_INC           = 32'd4;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INSN_W-1:0] insn;
    } fq_entry_t;
endpackage

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - instruction memory request/response bus
// Ports (master = fetch side, slave = memory side):
//   imem_req_valid/imem_req_ready/imem_req_addr : request handshake + address
//   imem_rsp_valid/imem_rsp_data                : in-order response, no backpressure
interface fetch_unit_if;
    import mips_pkg::*;

    logic              imem_req_valid;
    logic              imem_req_ready;
    logic [ADDR_W-1:0] imem_req_addr;
    logic              imem_rsp_valid;
    logic [INSN_W-1:0] imem_rsp_data;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data
    );
endinterface

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - synchronous FIFO with flush, used as the fetch instruction queue
// Ports: clk, rst (sync, active-high), flush (drop all entries), push/push_data,
//        pop, head_data (current head), empty, count (occupancy).
// Push and pop in the same cycle are legal at any occupancy, including full.
module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head_data,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             do_pop;
    logic             do_push;

    assign do_pop  = pop && (cnt != '0);
    // A pop in the same cycle frees the slot, so a full queue may still accept.
    assign do_push = push && ((cnt != CW'(DEPTH)) || do_pop);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            cnt <= cnt + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    assign head_data = mem[rd_ptr];
    assign empty     = (cnt == '0);
    assign count     = cnt;
endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - in-order instruction fetch with redirect and bounded queue
// Ports: clk, rst (sync, active-high); imem (fetch_unit_if.master) request/response bus;
//        redirect_valid/redirect_pc restart fetch; inst_valid/inst_ready/inst_data/
//        inst_pc/inst_pc_next present the queue head to decode.
module fetch_unit
    import mips_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int                DEPTH    = 2
) (
    input  logic              clk,
    input  logic              rst,
    fetch_unit_if.master      imem,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INSN_W-1:0] inst_data,
    output logic [ADDR_W-1:0] inst_pc,
    output logic [ADDR_W-1:0] inst_pc_next
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] rsp_pc;      // address of the next non-stale response
    logic [ADDR_W-1:0] redirect_aligned;
    logic [CW-1:0]     inflight;
    logic [CW-1:0]     stale;
    logic [CW-1:0]     occ;
    logic [CW:0]       used;
    logic              fifo_empty;
    fq_entry_t         head;
    fq_entry_t         push_entry;
    logic              pop;
    logic              accept;
    logic              rsp_stale;
    logic              push;

    assign redirect_aligned = {redirect_pc[ADDR_W-1:2], 2'b00};

    assign pop = inst_valid && inst_ready;

    // Credit check: queue slots plus everything outstanding (live or stale).
    // The head leaving this cycle returns its credit immediately so a
    // 1-cycle memory with a ready consumer sustains one fetch per cycle.
    assign used = (CW+1)'(occ) + (CW+1)'(inflight) + (CW+1)'(stale) - (CW+1)'(pop);

    assign imem.imem_req_valid = !rst && !redirect_valid && (used < (CW+1)'(DEPTH));
    assign imem.imem_req_addr  = fetch_pc;
    assign accept              = imem.imem_req_valid && imem.imem_req_ready;

    // Stale requests were all issued before any live one, so while stale is
    // non-zero the returning response must be one of them.
    assign rsp_stale = imem.imem_rsp_valid && (stale != '0);
    assign push      = imem.imem_rsp_valid && !rsp_stale && !redirect_valid;

    assign push_entry.pc   = rsp_pc;
    assign push_entry.insn = imem.imem_rsp_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            rsp_pc   <= RESET_PC;
            inflight <= '0;
            stale    <= '0;
        end else if (redirect_valid) begin
            fetch_pc <= redirect_aligned;
            rsp_pc   <= redirect_aligned;
            inflight <= '0;
            // Whatever returns this cycle is dropped; the rest becomes stale.
            stale    <= stale + inflight - CW'(imem.imem_rsp_valid);
        end else begin
            if (accept) fetch_pc <= fetch_pc + PC_INC;
            if (push)   rsp_pc   <= rsp_pc + PC_INC;
            inflight <= inflight + CW'(accept) - CW'(push);
            stale    <= stale - CW'(rsp_stale);
        end
    end

    sync_fifo #(
        .WIDTH ($bits(fq_entry_t)),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head_data (head),
        .empty     (fifo_empty),
        .count     (occ)
    );

    assign inst_valid   = !rst && !fifo_empty;
    assign inst_data    = inst_valid ? head.insn : '0;
    assign inst_pc      = inst_valid ? head.pc : '0;
    assign inst_pc_next = inst_valid ? (head.pc + PC_INC) : '0;
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning first fetch address after reset.
REQ-002 SHALL have parameter DEPTH, default 2, meaning instruction queue entries and maximum in-flight requests; power of two, 2..8.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port imem_req_valid  output  1  fetch request present.
REQ-006 SHALL have port imem_req_ready  input  1  memory accepts request this cycle.
REQ-007 SHALL have port imem_req_addr  output  32  word-aligned fetch address.
REQ-008 SHALL have port imem_rsp_valid  input  1  instruction word returned, in request order, at least 1 cycle after acceptance.
REQ-009 SHALL have port imem_rsp_data  input  32  returned instruction word.
REQ-010 SHALL have port redirect_valid  input  1  branch/jump taken; restart fetch.
REQ-011 SHALL have port redirect_pc  input  32  new fetch address; bits [1:0] ignored (forced 0).
REQ-012 SHALL have port inst_valid  output  1  queue head valid toward decode/control.
REQ-013 SHALL have port inst_ready  input  1  consumer takes head this cycle.
REQ-014 SHALL have port inst_data  output  32  head instruction word.
REQ-015 SHALL have port inst_pc  output  32  address of head instruction.
REQ-016 SHALL have port inst_pc_next  output  32  inst_pc + 4, modulo 2^32.

Function
REQ-017 SHALL hold fetch_pc; imem_req_addr = fetch_pc whenever imem_req_valid is 1.
REQ-018 SHALL assert imem_req_valid iff not rst, not redirect_valid, and (queue occupancy + in-flight count) < DEPTH.
REQ-019 SHALL, on request accept (valid & ready), advance fetch_pc by 4 and increment in-flight; 32'hFFFF_FFFC wraps to 0.
REQ-020 SHALL write each non-stale response (data plus its request address) into queue tail and decrement in-flight in the same cycle.
REQ-021 SHALL make a written response visible on inst_* the following cycle (1-cycle rsp-to-inst latency; no bypass).
REQ-022 SHALL pop the head on inst_valid & inst_ready; simultaneous push and pop SHALL be legal at any occupancy, including full.
REQ-023 SHALL hold inst_data/inst_pc stable while inst_valid & !inst_ready.
REQ-024 SHALL, on redirect_valid: empty queue, load fetch_pc = {redirect_pc[31:2],2'b00}, convert all in-flight (including any accepted the same cycle) to stale, issue no request that cycle.
REQ-025 SHALL discard stale responses (decrement stale count, no queue write); a response arriving in the redirect cycle SHALL be discarded.
REQ-026 SHALL resume requests the cycle after redirect at the new fetch_pc, subject to REQ-018 with stale responses counted as in-flight.
REQ-027 SHALL treat a pop coinciding with redirect as completed (consumer owns it); remaining entries flushed.
REQ-028 SHALL never overflow: accepted-but-unreturned plus occupancy never exceeds DEPTH.

Reset
REQ-029 SHALL on rst set fetch_pc = RESET_PC, queue empty, in-flight = 0, stale = 0.
REQ-030 SHALL drive imem_req_valid = 0 and inst_valid = 0 during and in the cycle of rst; inst_data/inst_pc/inst_pc_next = 0.
REQ-031 SHALL require instruction memory to share rst so no response survives reset; rst mid-operation SHALL abandon all in-flight work.

Structure
REQ-032 SHALL take INSN_W (32), ADDR_W (32), RESET_PC default and PC increment (4) from shared package mips_pkg.
REQ-033 SHALL implement the queue as one sub-module sync_fifo (width 64 = {pc, insn}, depth DEPTH, sync rst).
REQ-034 SHALL keep in-flight and stale counters clog2(DEPTH)+1 bits wide in fetch_unit.

Verification
REQ-035 SHALL cover reset then ready=1, 1-cycle memory, inst_ready=1 -> inst_pc 0,4,8,... one per cycle after 2-cycle fill.
REQ-036 SHALL cover inst_ready=0 with DEPTH=2 -> exactly 2 requests accepted, imem_req_valid drops, head stable at pc 0.
REQ-037 SHALL cover redirect to 32'h0000_0103 with 2 in flight -> both responses discarded, next request addr 32'h0000_0100, first inst_pc 32'h100.
REQ-038 SHALL cover RESET_PC 32'hFFFF_FFF8 -> inst_pc FFFF_FFF8, FFFF_FFFC, 0000_0000; inst_pc_next of FFFF_FFFC = 0.
REQ-039 SHALL cover random imem_req_ready/rsp latency 1..4/inst_ready with random redirects -> scoreboard: inst_data = mem[inst_pc], no loss, no duplicate, never >DEPTH outstanding.
REQ-040 SHALL cover rst asserted mid-stream with full queue -> next cycle inst_valid 0, first request addr RESET_PC.
